// File: rtl/uart_boot_loader.sv
// uart_boot_loader: UART boot receiver. Waits for ON_BYTE, holds the core in
// reset, receives a little-endian word count plus payload, writes the payload
// word by word into RAM and releases the core on STP_BYTE.
// Optional build macro: UART_BOOT_CHECKSUM_EN adds an 8-bit payload checksum
// byte (CSUM state) between the last data word and the terminator.
module uart_boot_loader #(
  parameter int unsigned BAUD_DIV = 768,
  parameter int unsigned ADDR_W   = 15,
  parameter logic [7:0]  ON_BYTE  = 8'hAA,
  parameter logic [7:0]  STP_BYTE = 8'h55
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              RX,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              err
);

  localparam int unsigned CNT_W     = $clog2(BAUD_DIV);
  localparam int unsigned HALF_CNT  = BAUD_DIV / 2 - 1;
  localparam int unsigned FULL_CNT  = BAUD_DIV - 1;
  localparam int unsigned WC_W      = ADDR_W - 1;
  localparam int unsigned MAX_WORDS = 32'd1 << (ADDR_W - 2);

  // ---------------------------------------------------------------------------
  // RX synchronizer and edge history
  // ---------------------------------------------------------------------------
  logic rx_meta;
  logic rx_sync;
  logic rx_prev;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // ---------------------------------------------------------------------------
  // 8N1 byte receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  rx_state_t        rx_state;
  rx_state_t        rx_next;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_shift;
  logic             byte_vld;
  logic             fe;
  logic             baud_half;
  logic             baud_full;

  assign baud_half = (baud_cnt == CNT_W'(HALF_CNT));
  assign baud_full = (baud_cnt == CNT_W'(FULL_CNT));

  // Receiver state register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) rx_state <= R_IDLE;
    else        rx_state <= rx_next;
  end

  // Receiver next state: start recheck at half bit, then full-bit sampling.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      R_IDLE:  if (rx_prev && !rx_sync) rx_next = R_START;
      R_START: if (baud_half) rx_next = rx_sync ? R_IDLE : R_DATA;
      R_DATA:  if (baud_full && (bit_idx == 3'd7)) rx_next = R_STOP;
      R_STOP:  if (baud_full) rx_next = R_IDLE;
      default: rx_next = R_IDLE;
    endcase
  end

  // Receiver datapath: bit timer, LSB-first shifter and registered pulses.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      rx_shift <= '0;
      byte_vld <= 1'b0;
      fe       <= 1'b0;
    end else begin
      if ((rx_state == R_IDLE) || baud_full || ((rx_state == R_START) && baud_half))
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + CNT_W'(1);

      if (rx_state == R_START)
        bit_idx <= '0;
      else if ((rx_state == R_DATA) && baud_full)
        bit_idx <= bit_idx + 3'd1;

      if ((rx_state == R_DATA) && baud_full)
        rx_shift <= {rx_sync, rx_shift[7:1]};

      byte_vld <= (rx_state == R_STOP) && baud_full && rx_sync;
      fe       <= (rx_state == R_STOP) && baud_full && !rx_sync;
    end
  end

  // ---------------------------------------------------------------------------
  // Load FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {L_IDLE, L_LEN, L_DATA, L_CSUM, L_STOP, L_HOLD} ld_state_t;

  ld_state_t         ld_state;
  ld_state_t         ld_next;
  ld_state_t         after_data;
  logic [1:0]        byte_cnt,  byte_cnt_d;
  logic [23:0]       asm_q,     asm_d;
  logic [WC_W-1:0]   word_cnt,  word_cnt_d;
  logic [ADDR_W-1:0] wr_addr,   wr_addr_d;
  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [31:0]       mem_wdata_d;
  logic              core_rst_n_d;
  logic              busy_d;
  logic              err_d;
  logic              is_on;
  logic              word_done;
  logic [31:0]       word;
  logic              len_bad;
  logic              len_zero;
  logic              last_word;
`ifdef UART_BOOT_CHECKSUM_EN
  logic [7:0]        csum, csum_d;
`endif

  assign is_on     = byte_vld && (rx_shift == ON_BYTE);
  assign word_done = byte_vld && (byte_cnt == 2'd3);
  assign word      = {rx_shift, asm_q};
  assign len_bad   = (word > MAX_WORDS);
  assign len_zero  = (word == 32'd0);
  assign last_word = (word_cnt == WC_W'(1));
`ifdef UART_BOOT_CHECKSUM_EN
  assign after_data = L_CSUM;
`else
  assign after_data = L_STOP;
`endif

  // Load state register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) ld_state <= L_IDLE;
    else        ld_state <= ld_next;
  end

  // Load next state; framing errors abort any active phase into HOLD.
  always_comb begin
    ld_next = ld_state;
    case (ld_state)
      L_IDLE, L_HOLD: if (is_on) ld_next = L_LEN;
      L_LEN: begin
        if (fe) ld_next = L_HOLD;
        else if (word_done) begin
          if (len_bad)       ld_next = L_HOLD;
          else if (len_zero) ld_next = after_data;
          else               ld_next = L_DATA;
        end
      end
      L_DATA: begin
        if (fe)                          ld_next = L_HOLD;
        else if (word_done && last_word) ld_next = after_data;
      end
`ifdef UART_BOOT_CHECKSUM_EN
      L_CSUM: begin
        if (fe)            ld_next = L_HOLD;
        else if (byte_vld) ld_next = (rx_shift == csum) ? L_STOP : L_HOLD;
      end
`endif
      L_STOP: begin
        if (fe)            ld_next = L_HOLD;
        else if (byte_vld) ld_next = (rx_shift == STP_BYTE) ? L_IDLE : L_HOLD;
      end
      default: ld_next = L_IDLE;
    endcase
  end

  // Load outputs and datapath next values, keyed on the current transition.
  always_comb begin
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    core_rst_n_d = core_rst_n;
    busy_d       = busy;
    err_d        = err;
    byte_cnt_d   = byte_cnt;
    asm_d        = asm_q;
    word_cnt_d   = word_cnt;
    wr_addr_d    = wr_addr;
`ifdef UART_BOOT_CHECKSUM_EN
    csum_d       = csum;
`endif

    if (((ld_state == L_IDLE) || (ld_state == L_HOLD)) && is_on) begin
      core_rst_n_d = 1'b0;
      busy_d       = 1'b1;
      err_d        = 1'b0;
      byte_cnt_d   = '0;
      word_cnt_d   = '0;
      wr_addr_d    = '0;
`ifdef UART_BOOT_CHECKSUM_EN
      csum_d       = '0;
`endif
    end

    if (((ld_state == L_LEN) || (ld_state == L_DATA)) && byte_vld) begin
      asm_d      = {rx_shift, asm_q[23:8]};
      byte_cnt_d = byte_cnt + 2'd1;
    end

    if ((ld_state == L_LEN) && word_done)
      word_cnt_d = word[WC_W-1:0];

    if ((ld_state == L_DATA) && byte_vld) begin
`ifdef UART_BOOT_CHECKSUM_EN
      csum_d = csum + rx_shift;
`endif
      if (word_done) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = wr_addr;
        mem_wdata_d = word;
        wr_addr_d   = wr_addr + ADDR_W'(4);
        word_cnt_d  = word_cnt - WC_W'(1);
      end
    end

    if ((ld_state == L_STOP) && (ld_next == L_IDLE)) begin
      core_rst_n_d = 1'b1;
      busy_d       = 1'b0;
    end

    if ((ld_state != L_HOLD) && (ld_next == L_HOLD)) begin
      err_d  = 1'b1;
      busy_d = 1'b0;
    end
  end

  // Load output and datapath registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_rst_n <= 1'b1;
      busy       <= 1'b0;
      err        <= 1'b0;
      byte_cnt   <= '0;
      asm_q      <= '0;
      word_cnt   <= '0;
      wr_addr    <= '0;
`ifdef UART_BOOT_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      core_rst_n <= core_rst_n_d;
      busy       <= busy_d;
      err        <= err_d;
      byte_cnt   <= byte_cnt_d;
      asm_q      <= asm_d;
      word_cnt   <= word_cnt_d;
      wr_addr    <= wr_addr_d;
`ifdef UART_BOOT_CHECKSUM_EN
      csum       <= csum_d;
`endif
    end
  end

endmodule
